// File: rtl/rs_pkg.sv
// Shared definitions for the RS(16,8) decoder front end.
//   RS_N / RS_K : codeword and message length in symbols
//   SYM_W       : symbol width in bits
//   sched_state_t : frame scheduler states (FILL, WAIT, SEND, GAP)
package rs_pkg;

   localparam int unsigned RS_N  = 16;
   localparam int unsigned RS_K  = 8;
   localparam int unsigned SYM_W = 8;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rs_frame_buf.sv
// One-frame symbol store for the frame scheduler.
// DEPTH x W register file, one synchronous write port, one asynchronous
// read port. Contents are not reset.
// Ports:
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module rs_frame_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 8,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rs_dec_frame_sched.sv
// Frame scheduler in front of rs_decoder_16_8.
// Collects one FRAME_LEN-symbol frame from a valid/ready source, then replays
// it to the decoder as one contiguous burst framed by sop/eop. Bursts are held
// back while MAX_INFLIGHT frames are still being output by the decoder; frames
// are retired by counting FRAME_LEN symb_out_val pulses. Decoder output with
// nothing outstanding raises a sticky unexp_out flag.
// Optional feature macro: RS_DEC_SCHED_STATS_EN builds the saturating
// frames_sent / frames_done counters; otherwise both ports are tied to 0.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   s_val, s_ready, s_data: upstream symbol stream
//   dec_din_val/sop/eop, dec_din : burst to decoder
//   dec_out_val           : decoder symb_out_val
//   inflight              : frames outstanding in the decoder
//   busy                  : scheduler not idle
//   unexp_out             : sticky unexpected-output flag
//   frames_sent/done      : statistics counters
module rs_dec_frame_sched
   import rs_pkg::*;
#(
   parameter int unsigned FRAME_LEN    = RS_N,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter int unsigned GAP_CYCLES   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_val,
   output logic             s_ready,
   input  logic [SYM_W-1:0] s_data,
   output logic             dec_din_val,
   output logic             dec_din_sop,
   output logic             dec_din_eop,
   output logic [SYM_W-1:0] dec_din,
   input  logic             dec_out_val,
   output logic [2:0]       inflight,
   output logic             busy,
   output logic             unexp_out,
   output logic [15:0]      frames_sent,
   output logic [15:0]      frames_done
);

   localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   // gap_cnt counts down to 0 inclusive, so load one less than the length
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   sched_state_t state_q, state_d;

   logic [CW-1:0]    wr_cnt;
   logic [CW-1:0]    rd_cnt;
   logic [CW-1:0]    out_cnt;
   logic [7:0]       gap_cnt;
   logic [2:0]       inflight_q;
   logic             unexp_q;
   logic [SYM_W-1:0] rd_data;

   logic accept;
   logic last_wr;
   logic eop_cyc;
   logic can_send;
   logic out_ok;
   logic inc_evt;
   logic dec_evt;

   assign accept   = s_val && (state_q == FILL);
   assign last_wr  = accept && (wr_cnt == LAST);
   assign eop_cyc  = (state_q == SEND) && (rd_cnt == LAST);
   assign can_send = (inflight_q < 3'(MAX_INFLIGHT));
   // Decoder output only counts toward a frame while one is outstanding
   assign out_ok   = dec_out_val && (inflight_q != 3'd0);
   assign inc_evt  = eop_cyc;
   assign dec_evt  = out_ok && (out_cnt == LAST);

   rs_frame_buf #(
      .DEPTH (FRAME_LEN),
      .W     (SYM_W),
      .AW    (CW)
   ) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_cnt),
      .wdata (s_data),
      .raddr (rd_cnt),
      .rdata (rd_data)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: if (last_wr)  state_d = WAIT;
         WAIT: if (can_send) state_d = SEND;
         SEND: if (eop_cyc)  state_d = (GAP_CYCLES > 0) ? GAP : FILL;
         GAP:  if (gap_cnt == 8'd0) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      s_ready     = (state_q == FILL);
      dec_din_val = (state_q == SEND);
      dec_din_sop = (state_q == SEND) && (rd_cnt == '0);
      dec_din_eop = eop_cyc;
      dec_din     = (state_q == SEND) ? rd_data : '0;
      busy        = (state_q != FILL) || (wr_cnt != '0) || (inflight_q != 3'd0);
   end

   // ------------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         gap_cnt <= '0;
      end else begin
         if (accept) begin
            wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
         end

         if (state_q == SEND) begin
            rd_cnt <= eop_cyc ? '0 : rd_cnt + 1'b1;
         end else begin
            rd_cnt <= '0;
         end

         if (eop_cyc) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state_q == GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
         end
      end
   end

   // ------------------------------------------------------ inflight tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_cnt    <= '0;
         inflight_q <= '0;
         unexp_q    <= 1'b0;
      end else begin
         if (out_ok) begin
            out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;
         end

         case ({inc_evt, dec_evt})
            2'b10:   inflight_q <= inflight_q + 3'd1;
            2'b01:   inflight_q <= inflight_q - 3'd1;
            default: inflight_q <= inflight_q;
         endcase

         if (dec_out_val && (inflight_q == 3'd0)) begin
            unexp_q <= 1'b1;
         end
      end
   end

   assign inflight  = inflight_q;
   assign unexp_out = unexp_q;

   // ---------------------------------------------------------- statistics
`ifdef RS_DEC_SCHED_STATS_EN
   logic [15:0] sent_q;
   logic [15:0] done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sent_q <= '0;
         done_q <= '0;
      end else begin
         if (inc_evt && (sent_q != '1)) begin
            sent_q <= sent_q + 16'd1;
         end
         if (dec_evt && (done_q != '1)) begin
            done_q <= done_q + 16'd1;
         end
      end
   end

   assign frames_sent = sent_q;
   assign frames_done = done_q;
`else
   assign frames_sent = '0;
   assign frames_done = '0;
`endif

endmodule

// File: tb/tb_rs_dec_frame_sched.sv
// Directed bench for rs_dec_frame_sched (FRAME_LEN=16, MAX_INFLIGHT=2,
// GAP_CYCLES=0). Inputs change 1 time unit after the rising edge; outputs are
// checked at the same point, i.e. they show the state after that edge.
module tb_rs_dec_frame_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_val;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        dec_din_val;
   logic        dec_din_sop;
   logic        dec_din_eop;
   logic [7:0]  dec_din;
   logic        dec_out_val;
   logic [2:0]  inflight;
   logic        busy;
   logic        unexp_out;
   logic [15:0] frames_sent;
   logic [15:0] frames_done;

   int checks = 0;
   int errors = 0;

   rs_dec_frame_sched #(
      .FRAME_LEN    (16),
      .MAX_INFLIGHT (2),
      .GAP_CYCLES   (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_val       (s_val),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .dec_din_val (dec_din_val),
      .dec_din_sop (dec_din_sop),
      .dec_din_eop (dec_din_eop),
      .dec_din     (dec_din),
      .dec_out_val (dec_out_val),
      .inflight    (inflight),
      .busy        (busy),
      .unexp_out   (unexp_out),
      .frames_sent (frames_sent),
      .frames_done (frames_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push 16 symbols base..base+15; optional one-cycle s_val drop between
   // symbols. Returns in the cycle after the last acceptance.
   task automatic push_frame(input int base, input bit stall);
      for (int i = 0; i < 16; i++) begin
         s_val  = 1'b1;
         s_data = 8'(base + i);
         tick();
         if (stall && i < 15) begin
            s_val  = 1'b0;
            s_data = 8'hEE;
            tick();
         end
      end
      s_val = 1'b0;
   endtask

   // Called from the WAIT cycle that precedes sop. Checks 16 contiguous burst
   // cycles; when pulse is set, dec_out_val is high in every burst cycle.
   task automatic burst(input int base, input bit pulse);
      for (int k = 0; k < 16; k++) begin
         tick();
         chk("burst_val", dec_din_val, 1'b1);
         chk("burst_din", dec_din, 32'(8'(base + k)));
         chk("burst_sop", dec_din_sop, (k == 0));
         chk("burst_eop", dec_din_eop, (k == 15));
         dec_out_val = pulse;
      end
      tick();
      dec_out_val = 1'b0;
      chk("post_burst_ready", s_ready, 1'b1);
      chk("post_burst_val", dec_din_val, 1'b0);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         dec_out_val = 1'b1;
         tick();
      end
      dec_out_val = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      s_val       = 1'b0;
      s_data      = 8'h00;
      dec_out_val = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_ready", s_ready, 1'b1);
      chk("rst_val", dec_din_val, 1'b0);
      chk("rst_sop", dec_din_sop, 1'b0);
      chk("rst_eop", dec_din_eop, 1'b0);
      chk("rst_din", dec_din, 8'h00);
      chk("rst_inflight", inflight, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_unexp", unexp_out, 1'b0);
      chk("rst_sent", frames_sent, 16'd0);
      chk("rst_done", frames_done, 16'd0);
      rst_n = 1'b1;
      tick();

      // Basic frame: WAIT at N+1, sop N+2, eop N+17, ready again N+18
      push_frame(0, 1'b0);
      chk("f1_wait_ready", s_ready, 1'b0);
      chk("f1_wait_val", dec_din_val, 1'b0);
      chk("f1_wait_busy", busy, 1'b1);
      burst(0, 1'b0);
      chk("f1_inflight", inflight, 3'd1);

      // Inflight throttle: second frame goes, third is held in WAIT
      push_frame(16, 1'b0);
      burst(16, 1'b0);
      chk("f2_inflight", inflight, 3'd2);
      push_frame(32, 1'b0);
      tick();
      tick();
      tick();
      chk("f3_held_ready", s_ready, 1'b0);
      chk("f3_held_val", dec_din_val, 1'b0);
      chk("f3_held_inflight", inflight, 3'd2);
      chk("f3_held_busy", busy, 1'b1);
      pulses(15);
      chk("f3_15_pulses_inflight", inflight, 3'd2);
      chk("f3_15_pulses_val", dec_din_val, 1'b0);
      pulses(1);
      chk("f3_released_inflight", inflight, 3'd1);
      chk("f3_released_val", dec_din_val, 1'b0);
      chk("f3_released_ready", s_ready, 1'b0);

      // Simultaneous: 16th decoder pulse lands on the eop of frame 3
      burst(32, 1'b1);
      chk("simul_inflight", inflight, 3'd1);
`ifdef RS_DEC_SCHED_STATS_EN
      chk("stats_sent", frames_sent, 16'd3);
      chk("stats_done", frames_done, 16'd2);
`else
      chk("stats_sent_off", frames_sent, 16'd0);
      chk("stats_done_off", frames_done, 16'd0);
`endif
      pulses(16);
      chk("drain_inflight", inflight, 3'd0);
      chk("drain_busy", busy, 1'b0);

      // Upstream stalls during fill; burst must still be contiguous
      push_frame(64, 1'b1);
      chk("stall_wait_ready", s_ready, 1'b0);
      burst(64, 1'b0);
      chk("stall_inflight", inflight, 3'd1);
      pulses(16);
      chk("stall_drain_inflight", inflight, 3'd0);

      // Unexpected decoder output
      pulses(1);
      chk("unexp_set", unexp_out, 1'b1);
      chk("unexp_inflight", inflight, 3'd0);
      tick();
      tick();
      chk("unexp_sticky", unexp_out, 1'b1);

      // out_cnt must not have advanced on the stray pulse
      push_frame(80, 1'b0);
      burst(80, 1'b0);
      pulses(15);
      chk("outcnt_15_inflight", inflight, 3'd1);
      pulses(1);
      chk("outcnt_16_inflight", inflight, 3'd0);
      chk("unexp_still", unexp_out, 1'b1);

      // Reset in the middle of a burst at rd_cnt=7
      push_frame(100, 1'b0);
      for (int k = 0; k < 8; k++) tick();
      chk("mid_val", dec_din_val, 1'b1);
      chk("mid_din", dec_din, 8'd107);
      rst_n = 1'b0;
      tick();
      chk("midrst_val", dec_din_val, 1'b0);
      chk("midrst_sop", dec_din_sop, 1'b0);
      chk("midrst_eop", dec_din_eop, 1'b0);
      chk("midrst_din", dec_din, 8'h00);
      chk("midrst_ready", s_ready, 1'b1);
      chk("midrst_inflight", inflight, 3'd0);
      chk("midrst_unexp", unexp_out, 1'b0);
      chk("midrst_sent", frames_sent, 16'd0);
      chk("midrst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("after_rst_ready", s_ready, 1'b1);
      chk("after_rst_val", dec_din_val, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
